// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with an ID/EX pipeline register, valid/ready on both sides,
// single-bubble load-use interlock, flush, and a saturating stall-cycle counter.
module id_stage_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [XLEN-1:0] InstAddrIn,
    input  logic [31:0]     InstIn,
    output logic [4:0]      Rs1AddrOut,
    output logic [4:0]      Rs2AddrOut,
    input  logic [XLEN-1:0] Rs1ReadDataIn,
    input  logic [XLEN-1:0] Rs2ReadDataIn,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] InstAddrOut,
    output logic [XLEN-1:0] Rs1DataOut,
    output logic [XLEN-1:0] Rs2DataOut,
    output logic [4:0]      RdAddrOut,
    output logic            RdWriteEnable,
    output logic [XLEN-1:0] Imm,
    output logic [6:0]      OpCode,
    output logic [2:0]      Funct3,
    output logic [6:0]      Funct7,
    output logic            Illegal,
    output logic [31:0]     StallCount
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rd_field;
    logic [4:0]      rs1_field;
    logic [4:0]      rs2_field;
    logic            rs1_re;
    logic            rs2_re;
    logic            rd_we;
    logic            illegal_d;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;
    logic            load_use;
    logic            capture;

    assign opcode    = InstIn[6:0];
    assign rd_field  = InstIn[11:7];
    assign rs1_field = InstIn[19:15];
    assign rs2_field = InstIn[24:20];

    always_comb begin
        rs1_re    = 1'b0;
        rs2_re    = 1'b0;
        rd_we     = 1'b0;
        illegal_d = 1'b0;
        imm32     = 32'd0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                rd_we = 1'b1;
                imm32 = {InstIn[31:12], 12'b0};
            end
            OPC_JAL: begin
                rd_we = 1'b1;
                imm32 = {{12{InstIn[31]}}, InstIn[19:12], InstIn[20], InstIn[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: begin
                rs1_re = 1'b1;
                rd_we  = 1'b1;
                imm32  = {{20{InstIn[31]}}, InstIn[31:20]};
            end
            OPC_MISC: begin
                rs1_re = 1'b1;
                rs2_re = 1'b1;
                rd_we  = 1'b1;
                imm32  = {{20{InstIn[31]}}, InstIn[31:20]};
            end
            OPC_BRANCH: begin
                rs1_re = 1'b1;
                rs2_re = 1'b1;
                imm32  = {{20{InstIn[31]}}, InstIn[7], InstIn[30:25], InstIn[11:8], 1'b0};
            end
            OPC_STORE: begin
                rs1_re = 1'b1;
                rs2_re = 1'b1;
                imm32  = {{20{InstIn[31]}}, InstIn[31:25], InstIn[11:7]};
            end
            OPC_OP: begin
                rs1_re = 1'b1;
                rs2_re = 1'b1;
                rd_we  = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Size cast of a signed value sign-extends to XLEN (no-op when XLEN is 32).
    assign imm_d = XLEN'($signed(imm32));

    assign Rs1AddrOut = rs1_re ? rs1_field : 5'd0;
    assign Rs2AddrOut = rs2_re ? rs2_field : 5'd0;

    // Unread register addresses are forced to 0, and a held rd of 0 never matches.
    assign load_use = OutValid && (OpCode == OPC_LOAD) && (RdAddrOut != 5'd0) && InValid &&
                      ((rs1_re && (rs1_field == RdAddrOut)) || (rs2_re && (rs2_field == RdAddrOut)));

    assign InReady = (!OutValid || OutReady) && !load_use && !Flush;
    assign capture = InValid && InReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            OutValid      <= 1'b0;
            InstAddrOut   <= '0;
            Rs1DataOut    <= '0;
            Rs2DataOut    <= '0;
            RdAddrOut     <= 5'd0;
            RdWriteEnable <= 1'b0;
            Imm           <= '0;
            OpCode        <= 7'd0;
            Funct3        <= 3'd0;
            Funct7        <= 7'd0;
            Illegal       <= 1'b0;
            StallCount    <= 32'd0;
        end else begin
            if (Flush) begin
                OutValid <= 1'b0;
            end else if (capture) begin
                OutValid <= 1'b1;
            end else if (OutValid && OutReady) begin
                OutValid <= 1'b0;
            end

            if (capture) begin
                InstAddrOut   <= InstAddrIn;
                Rs1DataOut    <= Rs1ReadDataIn;
                Rs2DataOut    <= Rs2ReadDataIn;
                RdAddrOut     <= rd_we ? rd_field : 5'd0;
                RdWriteEnable <= rd_we;
                Imm           <= imm_d;
                OpCode        <= opcode;
                Funct3        <= InstIn[14:12];
                Funct7        <= InstIn[31:25];
                Illegal       <= illegal_d;
            end

            // A bubble is only issued when the held load actually leaves.
            if (!Flush && load_use && OutReady && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: XLEN=64 and XLEN=32 instances share stimulus; a decode table,
// a handshake model and a scoreboard queue predict every output.
module tb_id_stage_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] imm;
        logic        ill;
        logic [63:0] pc;
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        Flush;
    logic        InValid;
    logic        OutReady;
    logic [31:0] InstIn;
    logic [63:0] InstAddrIn;
    logic [63:0] Rs1ReadDataIn;
    logic [63:0] Rs2ReadDataIn;

    logic        InReady, OutValid, RdWriteEnable, Illegal;
    logic [4:0]  Rs1AddrOut, Rs2AddrOut, RdAddrOut;
    logic [63:0] InstAddrOut, Rs1DataOut, Rs2DataOut, Imm;
    logic [6:0]  OpCode, Funct7;
    logic [2:0]  Funct3;
    logic [31:0] StallCount;

    logic        InReady_w, OutValid_w, RdWriteEnable_w, Illegal_w;
    logic [4:0]  Rs1AddrOut_w, Rs2AddrOut_w, RdAddrOut_w;
    logic [31:0] InstAddrOut_w, Rs1DataOut_w, Rs2DataOut_w, Imm_w;
    logic [6:0]  OpCode_w, Funct7_w;
    logic [2:0]  Funct3_w;
    logic [31:0] StallCount_w;

    id_stage_pipe #(.XLEN(64)) u_dut64 (
        .clock(clock), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .InstAddrIn(InstAddrIn), .InstIn(InstIn), .Rs1AddrOut(Rs1AddrOut), .Rs2AddrOut(Rs2AddrOut),
        .Rs1ReadDataIn(Rs1ReadDataIn), .Rs2ReadDataIn(Rs2ReadDataIn), .OutValid(OutValid),
        .OutReady(OutReady), .InstAddrOut(InstAddrOut), .Rs1DataOut(Rs1DataOut),
        .Rs2DataOut(Rs2DataOut), .RdAddrOut(RdAddrOut), .RdWriteEnable(RdWriteEnable), .Imm(Imm),
        .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7), .Illegal(Illegal), .StallCount(StallCount)
    );

    id_stage_pipe #(.XLEN(32)) u_dut32 (
        .clock(clock), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady_w),
        .InstAddrIn(InstAddrIn[31:0]), .InstIn(InstIn), .Rs1AddrOut(Rs1AddrOut_w),
        .Rs2AddrOut(Rs2AddrOut_w), .Rs1ReadDataIn(Rs1ReadDataIn[31:0]),
        .Rs2ReadDataIn(Rs2ReadDataIn[31:0]), .OutValid(OutValid_w), .OutReady(OutReady),
        .InstAddrOut(InstAddrOut_w), .Rs1DataOut(Rs1DataOut_w), .Rs2DataOut(Rs2DataOut_w),
        .RdAddrOut(RdAddrOut_w), .RdWriteEnable(RdWriteEnable_w), .Imm(Imm_w), .OpCode(OpCode_w),
        .Funct3(Funct3_w), .Funct7(Funct7_w), .Illegal(Illegal_w), .StallCount(StallCount_w)
    );

    always #5 clock = ~clock;

    vec_t        tbl[11];
    exp_t        sbq[$];
    exp_t        last;
    logic        m_valid;
    logic [6:0]  m_op;
    logic [4:0]  m_rd;
    logic [31:0] m_stall;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle(input int idx, input logic v, input logic ordy, input logic fl);
        vec_t t;
        exp_t e;
        logic lu, rdy, cap;
        t = tbl[idx];
        InValid       = v;
        InstIn        = t.inst;
        InstAddrIn    = {32'h8000_0000, $urandom};
        Rs1ReadDataIn = {$urandom, $urandom};
        Rs2ReadDataIn = {$urandom, $urandom};
        OutReady      = ordy;
        Flush         = fl;
        #1;
        lu  = m_valid && (m_op == 7'b0000011) && (m_rd != 5'd0) && v &&
              ((t.rs1a == m_rd) || (t.rs2a == m_rd));
        rdy = (!m_valid || ordy) && !lu && !fl;
        chk("in_ready", InReady, rdy);
        chk("in_ready32", InReady_w, rdy);
        chk("rs_addr", {Rs1AddrOut, Rs2AddrOut}, {t.rs1a, t.rs2a});
        chk("rs_addr32", {Rs1AddrOut_w, Rs2AddrOut_w}, {t.rs1a, t.rs2a});
        cap = v && rdy;
        if (cap) begin
            e.inst = t.inst; e.rd = t.rd; e.we = t.we; e.imm = t.imm; e.ill = t.ill;
            e.pc = InstAddrIn; e.d1 = Rs1ReadDataIn; e.d2 = Rs2ReadDataIn;
            sbq.push_back(e);
        end
        if (fl) m_valid = 1'b0;
        else if (cap) begin
            m_valid = 1'b1;
            m_op    = t.inst[6:0];
            m_rd    = t.rd;
        end else if (m_valid && ordy) m_valid = 1'b0;
        if (!fl && lu && ordy && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
        @(posedge clock);
        #1;
        chk("out_valid", OutValid, m_valid);
        chk("out_valid32", OutValid_w, m_valid);
        chk("stall_count", StallCount, m_stall);
        chk("stall_count32", StallCount_w, m_stall);
        if (cap) begin
            last = sbq.pop_front();
            chk("rd_addr", RdAddrOut, last.rd);
            chk("rd_we", RdWriteEnable, last.we);
            chk("imm", Imm, last.imm);
            chk("illegal", Illegal, last.ill);
            chk("op_f3_f7", {OpCode, Funct3, Funct7},
                {last.inst[6:0], last.inst[14:12], last.inst[31:25]});
            chk("pc", InstAddrOut, last.pc);
            chk("operands", {Rs1DataOut, Rs2DataOut}, {last.d1, last.d2});
            chk("imm32", Imm_w, last.imm[31:0]);
            chk("pc_ops32", {InstAddrOut_w, Rs1DataOut_w, Rs2DataOut_w},
                {last.pc[31:0], last.d1[31:0], last.d2[31:0]});
            chk("ctl32", {RdAddrOut_w, RdWriteEnable_w, Illegal_w, OpCode_w, Funct3_w, Funct7_w},
                {last.rd, last.we, last.ill, last.inst[6:0], last.inst[14:12], last.inst[31:25]});
        end else if (m_valid) begin
            chk("hold_bundle", {Imm, InstAddrOut}, {last.imm, last.pc});
            chk("hold_ops", {Rs1DataOut, Rs2DataOut}, {last.d1, last.d2});
        end
    endtask

    initial begin
        //             inst           rs1a   rs2a   rd     we    imm                       ill
        tbl[0]  = '{32'h00500093, 5'd0, 5'd0, 5'd1, 1'b1, 64'd5,                    1'b0}; // addi x1,x0,5
        tbl[1]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 1'b1, 64'h0000_0000_1234_5000, 1'b0}; // lui x5
        tbl[2]  = '{32'hFE000EE3, 5'd0, 5'd0, 5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}; // beq -4
        tbl[3]  = '{32'h0020A423, 5'd1, 5'd2, 5'd0, 1'b0, 64'd8,                    1'b0}; // sw x2,8(x1)
        tbl[4]  = '{32'h008000EF, 5'd0, 5'd0, 5'd1, 1'b1, 64'd8,                    1'b0}; // jal x1,8
        tbl[5]  = '{32'hFFFFF117, 5'd0, 5'd0, 5'd2, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 1'b0}; // auipc x2
        tbl[6]  = '{32'h0000007F, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0,                    1'b1}; // illegal
        tbl[7]  = '{32'h0000B103, 5'd1, 5'd0, 5'd2, 1'b1, 64'd0,                    1'b0}; // ld x2,0(x1)
        tbl[8]  = '{32'h001101B3, 5'd2, 5'd1, 5'd3, 1'b1, 64'd0,                    1'b0}; // add x3,x2,x1
        tbl[9]  = '{32'h0000B003, 5'd1, 5'd0, 5'd0, 1'b1, 64'd0,                    1'b0}; // ld x0,0(x1)
        tbl[10] = '{32'hFFF00093, 5'd0, 5'd0, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}; // addi x1,-1

        m_valid = 1'b0; m_op = 7'd0; m_rd = 5'd0; m_stall = 32'd0;
        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        InstIn = 32'd0; InstAddrIn = 64'd0; Rs1ReadDataIn = 64'd0; Rs2ReadDataIn = 64'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid_stall", {OutValid, StallCount, OutValid_w, StallCount_w}, 66'd0);
        chk("rst_bundle", {Imm, InstAddrOut, RdAddrOut, RdWriteEnable, Illegal}, 135'd0);
        chk("rst_fields", {OpCode, Funct3, Funct7, Rs1DataOut, Rs2DataOut}, 145'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", InReady, 1'b1);

        // Streaming decode of every table format with OutReady held high
        for (int i = 0; i <= 6; i++) cycle(i, 1'b1, 1'b1, 1'b0);

        // Load-use: one bubble, dependent accepted after the load leaves
        cycle(7, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);

        // Load into x0 never stalls
        cycle(9, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);

        // Load-use under back-pressure: no count until the load leaves
        cycle(7, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b0, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);

        // Flush beats load-use counting
        cycle(7, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b1);
        cycle(8, 1'b1, 1'b1, 1'b0);

        // Back-pressure for three cycles, capture on release edge
        cycle(0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1, 1'b1, 1'b0, 1'b0);
        cycle(1, 1'b1, 1'b1, 1'b0);

        // Flush with an offered instruction, then with a stalled bundle
        cycle(2, 1'b1, 1'b1, 1'b1);
        cycle(2, 1'b0, 1'b1, 1'b0);
        cycle(0, 1'b1, 1'b1, 1'b0);
        cycle(1, 1'b1, 1'b0, 1'b1);

        // Negative immediate through both widths, then drain
        cycle(10, 1'b1, 1'b1, 1'b0);
        cycle(6, 1'b1, 1'b1, 1'b0);
        cycle(0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with a load held and a nonzero stall count
        cycle(7, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {OutValid, OutValid_w}, 2'b00);
        chk("async_rst_stall", {StallCount, StallCount_w}, 64'd0);
        chk("async_rst_bundle", {Imm, RdAddrOut, OpCode, Illegal}, 77'd0);
        m_valid = 1'b0; m_stall = 32'd0;
        sbq.delete();
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        cycle(7, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);
        cycle(8, 1'b1, 1'b1, 1'b0);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, pipelined instruction-decode stage for the Balotelli RV32I/RV64I core. It decodes one instruction per cycle from the fetch stage and captures the result in an ID/EX pipeline register with valid/ready handshakes on both sides. It detects load-use hazards against the instruction it currently holds, inserts bubbles, supports a pipeline flush, and counts stall cycles. Immediates are emitted fully formed: U-type is shifted, and B/J-type have bit 0 cleared.

## Interface
Parameters:
- XLEN, 64, data/address width; legal values are 32 and 64.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Flush  in  1  kills the held instruction and the instruction currently offered.
- InValid  in  1  fetch offers an instruction.
- InReady  out  1  stage accepts this cycle.
- InstAddrIn  in  XLEN  PC of the offered instruction.
- InstIn  in  32  offered instruction.
- Rs1AddrOut, Rs2AddrOut  out  5  combinational register-file read addresses, decoded from InstIn.
- Rs1ReadDataIn, Rs2ReadDataIn  in  XLEN  register-file read data for the current Rs*AddrOut.
- OutValid  out  1  registered bundle is valid.
- OutReady  in  1  execute stage consumes the bundle.
- InstAddrOut  out  XLEN  registered PC.
- Rs1DataOut, Rs2DataOut  out  XLEN  registered operands.
- RdAddrOut  out  5  registered destination register.
- RdWriteEnable  out  1  registered destination write enable.
- Imm  out  XLEN  registered immediate.
- OpCode  out  7  registered opcode.
- Funct3  out  3  registered funct3.
- Funct7  out  7  registered funct7.
- Illegal  out  1  registered flag: the opcode is not one of the 11 supported opcodes.
- StallCount  out  32  saturating count of load-use bubble cycles.

## Operation
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- Read enable and read address per opcode:
  - rs1 is read by JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM and SYSTEM.
  - rs2 is read by BRANCH, STORE, OP and MISC-MEM.
  - For any register not read, the address is 0.
- rd is written by every supported opcode except BRANCH and STORE. When rd is not written, RdAddrOut is 0.
- Immediates are sign-extended to XLEN:
  - I-type: inst[31:20].
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - OP: Imm is 0.
- Illegal opcode:
  - Illegal=1.
  - All enables are 0, all addresses are 0, and Imm is 0.
  - OpCode, Funct3 and Funct7 pass through unchanged.
- LoadUse is asserted when all of the following hold:
  - OutValid=1 and the held OpCode is LOAD.
  - RdAddrOut is not 0.
  - InValid=1.
  - The offered instruction reads rs1 or rs2, and that register's address equals RdAddrOut.
- InReady = (!OutValid || OutReady) && !LoadUse && !Flush.
- Register update, evaluated in priority order:
  1. Flush: OutValid becomes 0 and the offered instruction is dropped.
  2. InValid && InReady: capture the decoded bundle and operands; OutValid becomes 1.
  3. OutValid && OutReady (consumed with no replacement, including the LoadUse case): OutValid becomes 0.
  4. Otherwise: hold all registers.
- StallCount increments in each cycle where LoadUse && OutReady holds (a bubble is issued). It saturates at 0xFFFFFFFF.
- Bundle registers change only on a capture. When OutValid=0, their contents are don't-care, except that they reset to 0.

## Timing
- Reset values: OutValid=0 and StallCount=0; all bundle outputs, including Illegal, are 0. InReady reads 1 out of reset when Flush=0.
- Latency: an instruction accepted at edge N is visible at the outputs after edge N, so the stage has 1 cycle of latency.
- Throughput: 1 instruction per cycle while OutReady stays high and no hazard occurs.
- Back-pressure: when OutValid=1 and OutReady=0, the bundle stays stable and InReady=0.
- Load-use: exactly one bubble is inserted.
  - The dependent instruction must be held at the input by fetch.
  - It is accepted on the cycle after the load leaves.
- A load whose rd is x0 never causes a stall.
- Flush takes precedence over a simultaneous capture, and over LoadUse counting.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. The held instruction is lost.

## Test plan
- Reset then stream, OutReady=1: 0x00500093 (addi x1,x0,5) then 0x123452B7 (lui x5,0x12345).
  - Required: back-to-back OutValid.
  - Bundle 1: Imm=5, RdAddrOut=1, RdWriteEnable=1.
  - Bundle 2: Imm=0x12345000, Rs1AddrOut=0 during its decode cycle.
- Offer 0xFE000EE3 (beq x0,x0,-4).
  - Required: Imm=0xFFFF_FFFF_FFFF_FFFC (XLEN=64), RdWriteEnable=0, Rs2AddrOut=0.
- Offer 0x0000B103 (ld x2,0(x1)) then 0x001101B3 (add x3,x2,x1).
  - Required: InReady=0 for one cycle and one OutValid=0 bubble.
  - Then add is captured, and StallCount=1.
  - Repeat with ld x0 as the load: no bubble occurs.
- Back-pressure: hold OutReady=0 for 3 cycles with a valid bundle.
  - Required: outputs stable and InReady=0.
  - On release, the next instruction is captured on the same edge.
- Flush together with InValid=1.
  - Required: OutValid=0 the next cycle and the offered instruction is discarded.
- Offer 0x0000007F.
  - Required: Illegal=1, all enables 0, Imm=0.
  - Rerun the stream test with XLEN=32: addi with Imm=0xFFF gives Imm=0xFFFFFFFF.
